// File: rtl/apb_bridge_n_if.sv
// Command/response port plus APB bus bundle for apb_bridge_n.
// master = the bridge side, slave = the command source and the APB slaves.
interface apb_bridge_n_if #(
    parameter int DATA_W  = 8,
    parameter int SLV_AW  = 8,
    parameter int NUM_SLV = 2
);
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int AW    = SLV_AW + SEL_W;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_write;
    logic [AW-1:0]               cmd_addr;
    logic [DATA_W-1:0]           cmd_wdata;
    logic                        rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic                        rsp_err;
    logic                        rsp_timeout;
    logic [7:0]                  err_cnt;
    logic [NUM_SLV-1:0]          psel;
    logic                        penable;
    logic                        pwrite;
    logic [SLV_AW-1:0]           paddr;
    logic [DATA_W-1:0]           pwdata;
    logic [NUM_SLV*DATA_W-1:0]   prdata_all;
    logic [NUM_SLV-1:0]          pready;
    logic [NUM_SLV-1:0]          pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata_all, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_cnt,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata_all, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_cnt,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_bridge_n.sv
// APB master bridge: one command at a time, SETUP then ACCESS (+waits), one-cycle response pulse.
// Issue interval 3 cycles at zero wait; cmd_ready low while busy; response has no backpressure.
module apb_bridge_n #(
    parameter int DATA_W  = 8,
    parameter int SLV_AW  = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          rst_n,
    apb_bridge_n_if.master bus
);
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int AW    = SLV_AW + SEL_W;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SEL_W:0] NUM_SLV_W = (SEL_W + 1)'(NUM_SLV);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        state;
    logic [SEL_W-1:0]  idx_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              pwrite_q;
    logic [SLV_AW-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [7:0]        err_cnt_q;

    logic [SEL_W-1:0]   cmd_idx;
    logic               decode_ok;
    logic [NUM_SLV-1:0] sel_onehot;
    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;
    logic               tmo_hit;

    assign cmd_idx   = bus.cmd_addr[AW-1:SLV_AW];
    assign decode_ok = ({1'b0, cmd_idx} < NUM_SLV_W);
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Only the addressed slave's ready/error/data are looked at.
    always_comb begin
        sel_onehot = '0;
        sel_ready  = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_ready     = bus.pready[i];
                sel_err       = bus.pslverr[i];
                sel_rdata     = bus.prdata_all[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx_q         <= '0;
            tmo_cnt       <= '0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;

            if (rsp_valid_q && rsp_err_q && (err_cnt_q != 8'hFF))
                err_cnt_q <= err_cnt_q + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        pwrite_q <= bus.cmd_write;
                        idx_q    <= cmd_idx;
                        paddr_q  <= bus.cmd_addr[SLV_AW-1:0];
                        pwdata_q <= bus.cmd_wdata;
                        if (decode_ok) begin
                            state   <= ST_SETUP;
                            tmo_cnt <= '0;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    tmo_cnt <= '0;
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= sel_err;
                        rsp_rdata_q <= (!pwrite_q && !sel_err) ? sel_rdata : '0;
                    end else if (tmo_hit) begin
                        state         <= ST_IDLE;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Select/enable decode straight from state so reset clears them without a clock.
    assign bus.cmd_ready   = (state == ST_IDLE);
    assign bus.psel        = (state != ST_IDLE) ? sel_onehot : '0;
    assign bus.penable     = (state == ST_ACCESS);
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.err_cnt     = err_cnt_q;
endmodule

// File: doc/apb_bridge_n.md
# apb_bridge_n

Parametrised APB master bridge: accepts single read/write commands on a valid/ready port and runs each one as an APB SETUP/ACCESS transfer to one of NUM_SLV slaves. The upper address bits select the slave. Each completed transfer returns a one-cycle response pulse. This is the next-generation replacement for the fixed two-slave, 8-bit top level. It adds generic data/address width and slave count, wait-state support, PSLVERR propagation, decode-error detection, an ACCESS timeout and an error counter.

## Interface
- DATA_W, 8: APB data width.
- SLV_AW, 8: per-slave offset width.
- NUM_SLV, 2: number of slaves, 1..16.
- TIMEOUT, 16: maximum ACCESS cycles before abort. 0 disables the timeout.
- Derived: SEL_W = max(1, clog2(NUM_SLV)); AW = SLV_AW + SEL_W.

Ports (one clock; reset is asynchronous and active-low):
- PCLK  in  1  clock, all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  bridge can accept a command.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  AW  [AW-1:SLV_AW] = slave index, [SLV_AW-1:0] = offset.
- CMD_WDATA  in  DATA_W  write data.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  DATA_W  read data. 0 on writes and on any error.
- RSP_ERR  out  1  transfer failed (PSLVERR, decode or timeout).
- RSP_TIMEOUT  out  1  failure cause was timeout.
- ERR_CNT  out  8  saturating count of RSP_ERR pulses.
- PSEL  out  NUM_SLV  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  SLV_AW  APB offset.
- PWDATA  out  DATA_W  APB write data.
- PRDATA_ALL  in  NUM_SLV*DATA_W  slave i data at [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLV  per-slave ready.
- PSLVERR  in  NUM_SLV  per-slave error.

## Operation
- States: IDLE, SETUP, ACCESS.
- Reset values: state=IDLE, CMD_READY=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, RSP_*=0, ERR_CNT=0, timeout counter=0.
- IDLE
  - CMD_READY=1.
  - On CMD_VALID at an edge, latch write, index, offset and wdata.
  - If index < NUM_SLV, go to SETUP.
  - Otherwise (decode error), stay in IDLE and pulse RSP_VALID=1, RSP_ERR=1 next cycle. No PSEL is asserted.
- SETUP
  - PSEL[index]=1, PENABLE=0. PADDR, PWRITE, PWDATA driven from the latched command.
  - Unconditionally go to ACCESS.
  - CMD_READY=0.
- ACCESS
  - PSEL[index]=1, PENABLE=1. Address, control and data stay stable.
  - Each edge samples PREADY[index].
  - If PREADY[index]=1, the transfer completes:
    - Go to IDLE.
    - RSP_VALID=1 for one cycle.
    - RSP_ERR=PSLVERR[index].
    - RSP_RDATA = PRDATA_ALL slice if read and no error, else 0.
  - Else, if TIMEOUT≠0 and this is the TIMEOUT-th ACCESS edge:
    - Abort and go to IDLE.
    - RSP_VALID=1, RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0.
  - Else, stay in ACCESS and increment the counter. The counter clears on entry to SETUP.
- PSEL and PENABLE drop to 0 in the cycle after completion or abort. PADDR, PWRITE and PWDATA hold their last values in IDLE.
- PREADY, PSLVERR and PRDATA of non-selected slaves are ignored.
- ERR_CNT increments on every RSP_VALID&RSP_ERR and saturates at 255.
- RSP_TIMEOUT=0 whenever RSP_VALID=0 or the error was not a timeout.
- RSP has no backpressure.

## Timing
- Command accepted at edge E0.
- SETUP occupies E0–E1; ACCESS occupies E1–E2.
- Zero wait states: PREADY=1 at E2, RSP_VALID high E2–E3, CMD_READY high E2 onward. Next command accepted at E3 at the earliest, i.e. a 3-cycle issue interval.
- Each PREADY-low ACCESS edge adds one cycle.
- Timeout abort: RSP_VALID in the cycle after the TIMEOUT-th ACCESS edge, i.e. at E(1+TIMEOUT).
- Decode error: RSP_VALID high E0–E1. The next command can be accepted at E1.
- Reset mid-transfer: all outputs return to their reset values immediately and asynchronously. No response is generated for the aborted command.

## Test plan
(DATA_W=8, SLV_AW=8, NUM_SLV=3, so SEL_W=2, AW=10, TIMEOUT=4.)
- Write 0x0A5 (slave 0, offset 0xA5), data 0x3C, slave 0 PREADY tied high -> PSEL=3'b001 in SETUP and ACCESS, PADDR=0xA5, PWDATA=0x3C, PWRITE=1; RSP_VALID 2 cycles after accept, RSP_ERR=0, RSP_RDATA=0.
- Read 0x110 (slave 1, offset 0x10), slave 1 returns 0x5A with PREADY low for 2 ACCESS cycles -> ACCESS lasts 3 cycles, RSP_RDATA=0x5A, RSP_ERR=0.
- Read 0x210 (slave 2) with PSLVERR[2]=1 at completion -> RSP_ERR=1, RSP_RDATA=0, RSP_TIMEOUT=0, ERR_CNT=1.
- Read 0x300 (index 3, out of range) -> PSEL stays 0, RSP_VALID the cycle after accept, RSP_ERR=1, ERR_CNT increments.
- Slave 0 PREADY held low -> abort after the 4th ACCESS edge, RSP_ERR=1, RSP_TIMEOUT=1, PSEL=0 the next cycle.
- Assert RST_N=0 during ACCESS -> PSEL and PENABLE are 0 immediately, no RSP_VALID, ERR_CNT=0; a fresh write after reset completes normally.
